// File: rtl/ccff_loader_pkg.sv
// ============================================================================
//  Module      : ccff_loader_pkg
//  Description : Shared state encoding and word-sizing helper for the
//                configuration-chain bitstream loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of bits a freshly captured word contributes to the chain.
  function automatic logic [31:0] bits_this_word(input logic [31:0] remaining,
                                                 input logic [31:0] word_w);
    return (remaining < word_w) ? remaining : word_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ccff_bitstream_loader_if.sv
// ============================================================================
//  Module      : ccff_bitstream_loader_if
//  Description : Valid/ready bitstream word stream into the chain loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 8
);

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

`default_nettype wire

// File: rtl/ccff_piso.sv
// ============================================================================
//  Module      : ccff_piso
//  Description : Parallel-in serial-out register, MSB first, with a count of
//                bits still to be presented from the current word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccff_piso #(
  parameter int WORD_W = 8,
  parameter int REM_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [REM_W-1:0]  load_bits,
  input  logic              shift,
  output logic              msb,
  output logic              last
);

  logic [WORD_W-1:0] r_shreg;
  logic [REM_W-1:0]  r_remaining;

  // A load in the same cycle as a shift wins: the outgoing bit is the
  // final one of the old word, so nothing of it needs to be kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg     <= '0;
      r_remaining <= '0;
    end else if (clr) begin
      r_shreg     <= '0;
      r_remaining <= '0;
    end else if (load) begin
      r_shreg     <= load_data;
      r_remaining <= load_bits;
    end else if (shift && (r_remaining != '0)) begin
      r_shreg     <= r_shreg << 1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

  assign msb  = r_shreg[WORD_W-1];
  assign last = (r_remaining == REM_W'(1));

endmodule

`default_nettype wire

// File: rtl/ccff_bitstream_loader.sv
// ============================================================================
//  Module      : ccff_bitstream_loader
//  Description : Serializes bitstream words MSB-first onto the configuration
//                flip-flop chain and counts exactly CHAIN_LEN bits.
//                Optional CCFF_READBACK_EN adds tail parity/ones readback.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  prog_rst_n,
  input  logic                  start,
  input  logic                  abort,
  ccff_bitstream_loader_if.slave s_if,
  output logic                  ccff_head,
  output logic                  ccff_shift_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      bit_count
`ifdef CCFF_READBACK_EN
  ,
  output logic                  tail_parity,
  output logic [CNT_W-1:0]      tail_ones
`endif
);

  localparam int REM_W = $clog2(WORD_W + 1);

  state_e            r_state;
  logic              r_shift_en;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_bit_count;

  logic              w_piso_msb;
  logic              w_piso_last;
  logic              w_last_bit;
  logic              w_final_bit;
  logic              w_ready;
  logic              w_hs;
  logic              w_start_ok;
  logic              w_abort;
  logic [CNT_W-1:0]  w_bit_count_inc;
  logic [CNT_W-1:0]  w_cap_count;
  logic [CNT_W-1:0]  w_remaining;
  logic [REM_W-1:0]  w_cap_bits;

  assign w_bit_count_inc = r_bit_count + 1'b1;
  assign w_last_bit      = (r_state == SHIFT) && w_piso_last;
  assign w_final_bit     = w_last_bit && (w_bit_count_inc == CNT_W'(CHAIN_LEN));
  assign w_ready         = (r_state == LOAD) || (w_last_bit && !w_final_bit);
  assign w_hs            = s_if.s_valid && w_ready;
  assign w_start_ok      = (r_state == IDLE) && start && !abort;
  assign w_abort         = (r_state != IDLE) && abort;

  // A word captured in the last SHIFT cycle sees the count after that shift.
  assign w_cap_count = (r_state == LOAD) ? r_bit_count : w_bit_count_inc;
  assign w_remaining = CNT_W'(CHAIN_LEN) - w_cap_count;
  assign w_cap_bits  = REM_W'(bits_this_word(32'(w_remaining), 32'(WORD_W)));

  ccff_piso #(
    .WORD_W (WORD_W),
    .REM_W  (REM_W)
  ) u_piso (
    .clk       (prog_clk),
    .rst_n     (prog_rst_n),
    .clr       (w_abort || w_final_bit),
    .load      (w_hs && !abort),
    .load_data (s_if.s_data),
    .load_bits (w_cap_bits),
    .shift     (r_state == SHIFT),
    .msb       (w_piso_msb),
    .last      (w_piso_last)
  );

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_state     <= IDLE;
      r_shift_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bit_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state     <= LOAD;
            r_busy      <= 1'b1;
            r_bit_count <= '0;
          end
        end
        LOAD: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_hs) begin
            r_state    <= SHIFT;
            r_shift_en <= 1'b1;
          end
        end
        SHIFT: begin
          // The bit on ccff_head this cycle is clocked into the chain even on abort.
          r_bit_count <= w_bit_count_inc;
          if (abort) begin
            r_state    <= IDLE;
            r_shift_en <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_piso_last) begin
            if (w_final_bit) begin
              r_state    <= DONE;
              r_shift_en <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else if (!w_hs) begin
              r_state    <= LOAD;
              r_shift_en <= 1'b0;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_shift_en <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign s_if.s_ready  = w_ready;
  assign ccff_head     = w_piso_msb;
  assign ccff_shift_en = r_shift_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign bit_count     = r_bit_count;

`ifdef CCFF_READBACK_EN
  logic             r_tail_parity;
  logic [CNT_W-1:0] r_tail_ones;

  // Tail bits belong to the previously loaded image leaving the chain.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_tail_parity <= 1'b0;
      r_tail_ones   <= '0;
    end else if (w_start_ok) begin
      r_tail_parity <= 1'b0;
      r_tail_ones   <= '0;
    end else if (r_shift_en) begin
      r_tail_parity <= r_tail_parity ^ ccff_tail;
      r_tail_ones   <= r_tail_ones + CNT_W'(ccff_tail);
    end
  end

  assign tail_parity = r_tail_parity;
  assign tail_ones   = r_tail_ones;
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
// ============================================================================
//  Module      : tb_ccff_bitstream_loader
//  Description : Directed bench for the chain loader: a 16-bit and a 20-bit
//                chain instance driven from one shared source.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccff_bitstream_loader;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic       abort   = 1'b0;
  logic       s_valid = 1'b0;
  logic       sel     = 1'b0;
  logic [7:0] s_data  = 8'h00;

  always #5 clk = ~clk;

  ccff_bitstream_loader_if #(.WORD_W(8)) if_a ();
  ccff_bitstream_loader_if #(.WORD_W(8)) if_b ();

  assign if_a.s_data  = s_data;
  assign if_a.s_valid = s_valid;
  assign if_b.s_data  = s_data;
  assign if_b.s_valid = s_valid;

  logic       start_a, start_b;
  logic       a_head, a_sh, a_busy, a_done, a_tail;
  logic       b_head, b_sh, b_busy, b_done;
  logic [4:0] a_cnt, b_cnt;

  assign start_a = start && !sel;
  assign start_b = start && sel;

`ifdef CCFF_READBACK_EN
  logic       a_tp;
  logic [4:0] a_to;
  logic       unused_b_tp;
  logic [4:0] unused_b_to;
`endif

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(16)) u_dut_a (
    .prog_clk      (clk),
    .prog_rst_n    (rst_n),
    .start         (start_a),
    .abort         (abort),
    .s_if          (if_a),
    .ccff_head     (a_head),
    .ccff_shift_en (a_sh),
    .ccff_tail     (a_tail),
    .busy          (a_busy),
    .done          (a_done),
    .bit_count     (a_cnt)
`ifdef CCFF_READBACK_EN
    ,
    .tail_parity   (a_tp),
    .tail_ones     (a_to)
`endif
  );

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(20)) u_dut_b (
    .prog_clk      (clk),
    .prog_rst_n    (rst_n),
    .start         (start_b),
    .abort         (abort),
    .s_if          (if_b),
    .ccff_head     (b_head),
    .ccff_shift_en (b_sh),
    .ccff_tail     (1'b0),
    .busy          (b_busy),
    .done          (b_done),
    .bit_count     (b_cnt)
`ifdef CCFF_READBACK_EN
    ,
    .tail_parity   (unused_b_tp),
    .tail_ones     (unused_b_to)
`endif
  );

  // Downstream chain model for instance A; its tail feeds readback.
  logic [15:0] chain;
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) chain <= 16'h8001;
    else if (a_sh) chain <= {chain[14:0], a_head};
  end
  assign a_tail = chain[15];

  logic       t_head, t_sh, t_busy, t_done, t_ready;
  logic [4:0] t_cnt;
  assign t_head  = sel ? b_head : a_head;
  assign t_sh    = sel ? b_sh : a_sh;
  assign t_busy  = sel ? b_busy : a_busy;
  assign t_done  = sel ? b_done : a_done;
  assign t_ready = sel ? if_b.s_ready : if_a.s_ready;
  assign t_cnt   = sel ? b_cnt : a_cnt;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic       in_start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       ex_ready;
    logic       ex_sh;
    logic       ex_head;
    logic       ex_done;
    logic       ex_busy;
    logic [4:0] ex_cnt;
  } vec_t;

  vec_t vecs[20];

  logic [7:0]  src_words[4];
  logic [63:0] got_bits;
  int          nbits, bubbles, bubble_not_ready, ready_after_last, done_gap;
  logic        got_done, busy_at_done;
  logic [4:0]  cnt_at_done, first_cnt;

  // Runs one load with a well-behaved source that withholds s_valid for
  // 'stall' LOAD cycles before every word after the first.
  task automatic stream_load(input int nw, input int stall, input int budget);
    int idx, gap, last_sh;
    logic seen_bit, hs;
    idx = 0; gap = 0; last_sh = -1; seen_bit = 1'b0;
    got_bits = '0; nbits = 0; bubbles = 0; bubble_not_ready = 0;
    ready_after_last = 0; got_done = 1'b0; done_gap = -1;
    cnt_at_done = '0; first_cnt = '1; busy_at_done = 1'b1;
    start = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < budget && !got_done; c++) begin
      if (t_sh) begin
        if (!seen_bit) first_cnt = t_cnt;
        got_bits = {got_bits[62:0], t_head};
        nbits++;
        seen_bit = 1'b1;
        last_sh = c;
      end else if (seen_bit && t_busy) begin
        bubbles++;
        if (!t_ready) bubble_not_ready++;
      end
      if (idx == nw && t_ready) ready_after_last++;
      if (t_done) begin
        got_done = 1'b1; done_gap = c - last_sh;
        cnt_at_done = t_cnt; busy_at_done = t_busy;
      end
      s_valid = (idx < nw) && (gap == 0);
      s_data  = src_words[(idx < nw) ? idx : 0];
      if (gap > 0 && t_ready && !t_sh) gap--;
      hs = s_valid && t_ready;
      @(negedge clk);
      if (hs) begin
        idx++;
        gap = stall;
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    int   nb;
    logic flag;

    pat = 16'hA53C;
    vecs[0] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[1] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0};
    for (int k = 0; k < 16; k++)
      vecs[k+2] = '{1'b0, 1'b1, (k >= 7) ? 8'h3C : 8'hA5, (k == 7),
                    1'b1, pat[15-k], 1'b0, 1'b1, 5'(k)};
    vecs[18] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd16};
    vecs[19] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_a_sh", a_sh, 0);
    check("rst_a_head", a_head, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_cnt", a_cnt, 0);
    check("rst_a_ready", if_a.s_ready, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_ready", if_b.s_ready, 0);
    rst_n = 1'b1;
    preload = 1'b0;
    @(negedge clk);

    // Cycle table: 0xA5, 0x3C on a 16-bit chain, s_valid always high
    for (int i = 0; i < 20; i++) begin
      start = vecs[i].in_start; s_valid = vecs[i].in_valid; s_data = vecs[i].in_data;
      check($sformatf("vec%0d_ready", i), t_ready, vecs[i].ex_ready);
      check($sformatf("vec%0d_shift_en", i), t_sh, vecs[i].ex_sh);
      check($sformatf("vec%0d_head", i), t_head, vecs[i].ex_head);
      check($sformatf("vec%0d_done", i), t_done, vecs[i].ex_done);
      check($sformatf("vec%0d_busy", i), t_busy, vecs[i].ex_busy);
      check($sformatf("vec%0d_cnt", i), t_cnt, vecs[i].ex_cnt);
      @(negedge clk);
    end
    start = 1'b0; s_valid = 1'b0;

    // 20-bit chain: short final word
    sel = 1'b1;
    src_words[0] = 8'hFF; src_words[1] = 8'h00; src_words[2] = 8'hF0;
    stream_load(3, 0, 200);
    check("c20_done", got_done, 1);
    check("c20_nbits", nbits, 20);
    check("c20_bits", got_bits[19:0], 20'hFF00F);
    check("c20_ready_after_last", ready_after_last, 0);
    check("c20_bubbles", bubbles, 0);
    check("c20_done_gap", done_gap, 1);
    check("c20_cnt", cnt_at_done, 20);
    check("c20_busy_at_done", busy_at_done, 0);
    sel = 1'b0;

    // Source stalls 3 LOAD cycles between words
    src_words[0] = 8'h5A; src_words[1] = 8'hC3;
    stream_load(2, 3, 200);
    check("stall_done", got_done, 1);
    check("stall_nbits", nbits, 16);
    check("stall_bits", got_bits[15:0], 16'h5AC3);
    check("stall_bubbles", bubbles, 4);
    check("stall_bubble_not_ready", bubble_not_ready, 0);
    check("stall_cnt", cnt_at_done, 16);
    check("stall_first_cnt", first_cnt, 0);

    // Abort on the 5th bit of the first word
    start = 1'b1; s_data = 8'hA5; s_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0; flag = 1'b0;
    for (int c = 0; c < 20 && !flag; c++) begin
      if (t_sh) nb++;
      if (nb == 5) begin abort = 1'b1; flag = 1'b1; end
      @(negedge clk);
    end
    abort = 1'b0; s_valid = 1'b0;
    check("abort_reached", flag, 1);
    check("abort_shift_en", t_sh, 0);
    check("abort_busy", t_busy, 0);
    check("abort_ready", t_ready, 0);
    check("abort_cnt", t_cnt, 5);
    flag = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (t_done) flag = 1'b1;
    end
    check("abort_no_done", flag, 0);
    check("abort_cnt_held", t_cnt, 5);
    src_words[0] = 8'hA5; src_words[1] = 8'h3C;
    stream_load(2, 0, 200);
    check("restart_first_cnt", first_cnt, 0);
    check("restart_nbits", nbits, 16);
    check("restart_bits", got_bits[15:0], 16'hA53C);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", t_busy, 0);
    check("start_abort_ready", t_ready, 0);

    // Asynchronous reset while a 1 is on ccff_head
    start = 1'b1; s_data = 8'hA5; s_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    for (int c = 0; c < 20 && nb < 3; c++) begin
      @(negedge clk);
      if (t_sh) nb++;
    end
    check("pre_rst_head", t_head, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_shift_en", t_sh, 0);
    check("mid_rst_head", t_head, 0);
    check("mid_rst_busy", t_busy, 0);
    check("mid_rst_cnt", t_cnt, 0);
    check("mid_rst_ready", t_ready, 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stream_load(2, 0, 200);
    check("post_rst_nbits", nbits, 16);
    check("post_rst_bits", got_bits[15:0], 16'hA53C);

`ifdef CCFF_READBACK_EN
    // Tail readback of a chain holding 0x8001
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    stream_load(2, 0, 200);
    check("rb_done", got_done, 1);
    check("rb_tail_ones", a_to, 2);
    check("rb_tail_parity", a_tp, 0);
    @(negedge clk);
    check("rb_tail_ones_stable", a_to, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
